// File: rtl/adder_sum_accumulator.sv
// Accumulates a burst of N_TERMS unsigned adder sums into a saturating ACC_W-bit total
// and hands the result and a sticky overflow flag downstream over a valid/ready handshake.
module adder_sum_accumulator #(
    parameter int IN_W    = 12,
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for start; last result held on out_acc/out_ovf
    // ACCUM | accepting terms, one per cycle when in_valid
    // DONE  | result presented until out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(N_TERMS + 1);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] res_acc;
    logic             res_ovf;
    logic [ACC_W:0]   sum;
    logic             xfer;
    logic             last;

    assign xfer = (state == ACCUM) && in_valid;
    assign last = (count == CNT_W'(N_TERMS - 1));
    assign sum  = {1'b0, acc} + (ACC_W + 1)'(in_sum);

    // A carry out of the extra bit pins the total at all ones; a saturated acc
    // can only carry again or stay put, so it remains saturated for the burst.
    always_comb begin
        acc_nxt = sum[ACC_W-1:0];
        ovf_nxt = ovf;
        if (sum[ACC_W]) begin
            acc_nxt = '1;
            ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (xfer && last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Result registers load with the final term so they stay put after DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            ovf     <= 1'b0;
            count   <= '0;
            res_acc <= '0;
            res_ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (xfer) begin
            acc   <= acc_nxt;
            ovf   <= ovf_nxt;
            count <= count + CNT_W'(1);
            if (last) begin
                res_acc <= acc_nxt;
                res_ovf <= ovf_nxt;
            end
        end
    end

    assign out_acc = res_acc;
    assign out_ovf = res_ovf;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: default, ACC_W=13 and N_TERMS=1 instances share the
// input bus; each burst is checked against a saturating-sum reference model.
module tb_adder_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = '0;
    logic        in_valid = 1'b0;
    logic [11:0] in_sum = '0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, out_ovf0, busy0;
    logic [15:0] out_acc0;
    logic        in_ready1, out_valid1, out_ovf1, busy1;
    logic [12:0] out_acc1;
    logic        in_ready2, out_valid2, out_ovf2, busy2;
    logic [15:0] out_acc2;

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int terms[$];

    always #5 clk = ~clk;

    adder_sum_accumulator u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sum(in_sum), .out_valid(out_valid0), .out_ready(out_ready), .out_acc(out_acc0),
        .out_ovf(out_ovf0), .busy(busy0)
    );

    adder_sum_accumulator #(.ACC_W(13)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(in_ready1),
        .in_sum(in_sum), .out_valid(out_valid1), .out_ready(out_ready), .out_acc(out_acc1),
        .out_ovf(out_ovf1), .busy(busy1)
    );

    adder_sum_accumulator #(.N_TERMS(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(in_ready2),
        .in_sum(in_sum), .out_valid(out_valid2), .out_ready(out_ready), .out_acc(out_acc2),
        .out_ovf(out_ovf2), .busy(busy2)
    );

    logic        m_in_ready, m_out_valid, m_out_ovf, m_busy;
    logic [15:0] m_out_acc;

    always_comb begin
        m_in_ready  = in_ready0;
        m_out_valid = out_valid0;
        m_out_ovf   = out_ovf0;
        m_busy      = busy0;
        m_out_acc   = out_acc0;
        if (sel == 1) begin
            m_in_ready  = in_ready1;
            m_out_valid = out_valid1;
            m_out_ovf   = out_ovf1;
            m_busy      = busy1;
            m_out_acc   = {3'b000, out_acc1};
        end else if (sel == 2) begin
            m_in_ready  = in_ready2;
            m_out_valid = out_valid2;
            m_out_ovf   = out_ovf2;
            m_busy      = busy2;
            m_out_acc   = out_acc2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int acc_w_of(input int s);
        return (s == 1) ? 13 : 16;
    endfunction

    function automatic int n_of(input int s);
        return (s == 2) ? 1 : 4;
    endfunction

    // Reference: plain sum of the burst, clipped at the width's maximum.
    task automatic model(input int s, output logic [31:0] exp_acc, output logic [31:0] exp_ovf);
        longint tot = 0;
        longint mx  = (longint'(1) << acc_w_of(s)) - 1;
        foreach (terms[i]) tot += terms[i];
        exp_acc = (tot > mx) ? 32'(mx) : 32'(tot);
        exp_ovf = (tot > mx) ? 32'd1 : 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_burst(input int s, input int gap, input int hold, input bit noise);
        logic [31:0] exp_acc, exp_ovf;
        sel = s;
        model(s, exp_acc, exp_ovf);
        start_v[s] = 1'b1;
        tick();
        start_v[s] = 1'b0;
        chk("accum_busy", 32'(m_busy), 1);
        chk("accum_in_ready", 32'(m_in_ready), 1);
        foreach (terms[i]) begin
            for (int g = 0; g < gap; g++) begin
                in_valid   = 1'b0;
                in_sum     = 12'($urandom);
                start_v[s] = noise;
                tick();
                start_v[s] = 1'b0;
                chk("bubble_ready", 32'(m_in_ready), 1);
            end
            chk("early_valid", 32'(m_out_valid), 0);
            in_valid   = 1'b1;
            in_sum     = 12'(terms[i]);
            start_v[s] = noise;
            tick();
            in_valid   = 1'b0;
            start_v[s] = 1'b0;
        end
        chk("done_valid", 32'(m_out_valid), 1);
        chk("done_acc", 32'(m_out_acc), exp_acc);
        chk("done_ovf", 32'(m_out_ovf), exp_ovf);
        chk("done_in_ready", 32'(m_in_ready), 0);
        for (int h = 0; h < hold; h++) begin
            start_v[s] = noise;
            tick();
            start_v[s] = 1'b0;
            chk("hold_valid", 32'(m_out_valid), 1);
            chk("hold_acc", 32'(m_out_acc), exp_acc);
            chk("hold_in_ready", 32'(m_in_ready), 0);
        end
        out_ready  = 1'b1;
        start_v[s] = noise;
        tick();
        out_ready  = 1'b0;
        start_v[s] = 1'b0;
        chk("idle_valid", 32'(m_out_valid), 0);
        chk("idle_busy", 32'(m_busy), 0);
        chk("idle_keep_acc", 32'(m_out_acc), exp_acc);
        chk("idle_keep_ovf", 32'(m_out_ovf), exp_ovf);
        tick();
        chk("no_extra_burst", 32'(m_busy), 0);
    endtask

    initial begin
        logic [31:0] e_acc, e_ovf;
        int s;
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready0 | in_ready1 | in_ready2), 0);
        chk("rst_out_valid", 32'(out_valid0 | out_valid1 | out_valid2), 0);
        chk("rst_out_acc", 32'(out_acc0 | {3'b000, out_acc1} | out_acc2), 0);
        chk("rst_out_ovf", 32'(out_ovf0 | out_ovf1 | out_ovf2), 0);
        chk("rst_busy", 32'(busy0 | busy1 | busy2), 0);
        rst = 1'b0;
        tick();

        terms = '{100, 200, 300, 400};
        do_burst(0, 0, 0, 1'b0);
        do_burst(0, 2, 5, 1'b0);

        terms = '{4095, 4095, 4095, 1};
        do_burst(1, 0, 0, 1'b0);
        terms = '{1, 1, 1, 1};
        do_burst(1, 0, 0, 1'b0);

        terms = '{500, 7, 1234, 60};
        do_burst(0, 1, 3, 1'b1);

        terms = '{4095};
        do_burst(2, 0, 0, 1'b0);

        terms = '{0, 0, 0, 0};
        do_burst(0, 0, 1, 1'b0);

        terms = '{2000, 3000, 4000, 100};
        model(0, e_acc, e_ovf);
        do_burst(0, 0, 0, 1'b0);
        sel = 0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        in_valid = 1'b1;
        in_sum   = 12'd2000;
        tick();
        in_sum   = 12'd3000;
        tick();
        in_sum   = 12'd4000;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_in_ready", 32'(in_ready0), 0);
        chk("midrst_out_valid", 32'(out_valid0), 0);
        chk("midrst_out_acc", 32'(out_acc0), 0);
        chk("midrst_out_ovf", 32'(out_ovf0), 0);
        tick();
        chk("midrst_stay_idle", 32'(busy0), 0);

        terms = '{10, 20, 30, 40};
        do_burst(0, 0, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            s = int'($urandom_range(0, 2));
            terms.delete();
            for (int k = 0; k < n_of(s); k++) begin
                if ($urandom_range(0, 3) == 0) terms.push_back(4095);
                else terms.push_back(int'($urandom_range(0, 4095)));
            end
            do_burst(s, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
